// File: rtl/baggage_drop_pkg.sv
// Shared types and widths for the baggage-drop sequencer.
// State encoding is fixed because the display stage decodes it.
package baggage_drop_pkg;

    localparam int SENSOR_W    = 8;
    localparam int TIME_W      = 16;
    localparam int NUM_SENSORS = 4;
    localparam int SUM_W       = 10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_DROP = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/baggage_drop_sequencer_t_lim_calc.sv
// Combinational time-limit calculation from the four sensor heights.
// A zero height marks a faulty sensor and forces the limit to zero.
module t_lim_calc
    import baggage_drop_pkg::*;
#(
    parameter logic [TIME_W-1:0] T_BASE = 16'd100
) (
    input  logic [SENSOR_W*NUM_SENSORS-1:0] sensors,
    output logic [TIME_W-1:0]               t_lim
);

    logic [SUM_W-1:0]  sum;
    logic              any_zero;
    logic [TIME_W:0]   wide;

    // Sum heights, flag faulty sensors, saturate the base-plus-sum.
    always_comb begin
        sum      = '0;
        any_zero = 1'b0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            sum = sum + SUM_W'(sensors[i*SENSOR_W +: SENSOR_W]);
            if (sensors[i*SENSOR_W +: SENSOR_W] == '0)
                any_zero = 1'b1;
        end
        wide = {1'b0, T_BASE} + (TIME_W+1)'(sum);
        if (any_zero)
            t_lim = '0;
        else if (wide[TIME_W])
            t_lim = '1;
        else
            t_lim = wide[TIME_W-1:0];
    end

endmodule

// File: rtl/baggage_drop_sequencer.sv
// Baggage-drop controller: latches the time limit, counts elapsed
// ticks and opens a bounded drop window for the display/drop stage.
module baggage_drop_sequencer
    import baggage_drop_pkg::*;
#(
    parameter logic [TIME_W-1:0] T_BASE     = 16'd100,
    parameter logic [TIME_W-1:0] TIMEOUT    = 16'd5000,
    parameter logic [7:0]        HOLD_TICKS = 8'd50
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            tick,
    input  logic                            start,
    input  logic                            drop_req,
    input  logic                            abort,
    input  logic [SENSOR_W*NUM_SENSORS-1:0] sensors,
    output logic [TIME_W-1:0]               t_act,
    output logic [TIME_W-1:0]               t_lim,
    output logic                            drop_en,
    output logic                            busy,
    output logic                            done
);

    // A hold of zero ticks is treated as a single tick.
    localparam logic [7:0] HOLD_LAST =
        (HOLD_TICKS == 8'd0) ? 8'd0 : HOLD_TICKS - 8'd1;

    state_t            state;
    logic [7:0]        hold_cnt;
    logic [TIME_W-1:0] lim_calc;
    logic [TIME_W-1:0] t_act_inc;

    t_lim_calc #(
        .T_BASE (T_BASE)
    ) u_t_lim_calc (
        .sensors (sensors),
        .t_lim   (lim_calc)
    );

    // Elapsed-time increment that sticks at full scale.
    always_comb begin
        t_act_inc = t_act;
        if (t_act != '1)
            t_act_inc = t_act + 16'd1;
    end

    // Sequencer FSM with registered outputs; abort wins over everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            t_act    <= '0;
            t_lim    <= '0;
            drop_en  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hold_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (abort && state != S_IDLE) begin
                state   <= S_IDLE;
                busy    <= 1'b0;
                drop_en <= 1'b0;
                t_act   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state <= S_LOAD;
                            busy  <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        t_act <= '0;
                        t_lim <= lim_calc;
                        state <= S_RUN;
                    end
                    S_RUN: begin
                        if (drop_req) begin
                            state    <= S_DROP;
                            drop_en  <= 1'b1;
                            hold_cnt <= '0;
                            if (tick)
                                t_act <= t_act_inc;
                        end else if (t_act == TIMEOUT) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (tick) begin
                            t_act <= t_act_inc;
                        end
                    end
                    S_DROP: begin
                        if (tick) begin
                            if (hold_cnt == HOLD_LAST) begin
                                state   <= S_DONE;
                                drop_en <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                hold_cnt <= hold_cnt + 8'd1;
                            end
                        end
                    end
                    S_DONE: begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        drop_en <= 1'b0;
                    end
                    default: begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        drop_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_baggage_drop_sequencer.sv
// Self-checking bench for baggage_drop_sequencer.
// Two instances: default parameters, and a saturating/short-timeout one.
module tb_baggage_drop_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_tick, a_start, a_drop, a_abort;
    logic [31:0] a_sens;
    logic [15:0] a_t_act, a_t_lim;
    logic        a_drop_en, a_busy, a_done;

    logic        b_tick, b_start, b_drop, b_abort;
    logic [31:0] b_sens;
    logic [15:0] b_t_act, b_t_lim;
    logic        b_drop_en, b_busy, b_done;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    baggage_drop_sequencer u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (a_tick),
        .start    (a_start),
        .drop_req (a_drop),
        .abort    (a_abort),
        .sensors  (a_sens),
        .t_act    (a_t_act),
        .t_lim    (a_t_lim),
        .drop_en  (a_drop_en),
        .busy     (a_busy),
        .done     (a_done)
    );

    baggage_drop_sequencer #(
        .T_BASE     (16'hFF80),
        .TIMEOUT    (16'd20),
        .HOLD_TICKS (8'd0)
    ) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (b_tick),
        .start    (b_start),
        .drop_req (b_drop),
        .abort    (b_abort),
        .sensors  (b_sens),
        .t_act    (b_t_act),
        .t_lim    (b_t_lim),
        .drop_en  (b_drop_en),
        .busy     (b_busy),
        .done     (b_done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference limit: base plus heights, clamped, zero on any faulty sensor.
    function automatic int ref_lim(input int tbase, input logic [31:0] s);
        int sum;
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            if (s[i*8 +: 8] == 8'd0)
                return 0;
            sum += int'(s[i*8 +: 8]);
        end
        return (tbase + sum > 65535) ? 65535 : tbase + sum;
    endfunction

    task automatic a_begin(input logic [31:0] s);
        a_sens  = s;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        chk("load_busy", a_busy, 1);
        a_tick = 1'b1;
        step();
        a_tick = 1'b0;
        chk("run_t_lim", a_t_lim, ref_lim(100, s));
        chk("run_t_act0", a_t_act, 0);
    endtask

    task automatic a_run_ticks(input int n);
        int cnt;
        int cyc;
        cnt = 0;
        cyc = 0;
        while (cnt < n && cyc < 20000) begin
            a_tick  = 1'($urandom_range(0, 1));
            a_start = 1'($urandom_range(0, 1));
            step();
            cyc++;
            if (a_tick)
                cnt++;
        end
        a_tick  = 1'b0;
        a_start = 1'b0;
        chk("run_ticks_bound", cnt, n);
    endtask

    task automatic a_scenario(input logic [31:0] s, input int n);
        int dt;
        int exp_act;
        int ht;
        int cyc;
        bit bad;
        a_begin(s);
        a_run_ticks(n);
        chk("run_t_act", a_t_act, n);
        dt = int'($urandom_range(0, 1));
        a_drop = 1'b1;
        a_tick = 1'(dt);
        step();
        a_drop = 1'b0;
        a_tick = 1'b0;
        exp_act = n + dt;
        chk("drop_en_rise", a_drop_en, 1);
        chk("drop_t_act", a_t_act, exp_act);
        ht = 0;
        cyc = 0;
        bad = 1'b0;
        while (ht < 50 && cyc < 2000) begin
            a_tick = 1'($urandom_range(0, 1));
            a_drop = 1'($urandom_range(0, 1));
            step();
            cyc++;
            if (a_tick)
                ht++;
            if (ht < 50 && (a_drop_en !== 1'b1 || a_done !== 1'b0 ||
                            a_t_act !== 16'(exp_act)))
                bad = 1'b1;
        end
        a_tick = 1'b0;
        a_drop = 1'b0;
        chk("hold_window", 32'(bad), 0);
        chk("hold_ticks", ht, 50);
        chk("done_pulse", a_done, 1);
        chk("done_drop_en", a_drop_en, 0);
        chk("done_t_act", a_t_act, exp_act);
        chk("done_t_lim", a_t_lim, ref_lim(100, s));
        step();
        chk("idle_done", a_done, 0);
        chk("idle_busy", a_busy, 0);
        chk("idle_t_act", a_t_act, exp_act);
        chk("idle_t_lim", a_t_lim, ref_lim(100, s));
    endtask

    initial begin
        logic [31:0] s;
        a_tick = 0; a_start = 0; a_drop = 0; a_abort = 0; a_sens = '0;
        b_tick = 0; b_start = 0; b_drop = 0; b_abort = 0; b_sens = '0;
        #13;
        chk("rst_t_act", a_t_act, 0);
        chk("rst_t_lim", a_t_lim, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_drop_en", a_drop_en, 0);
        chk("rst_done", a_done, 0);
        #10;
        rst_n = 1'b1;
        step();
        chk("idle_after_rst", a_busy, 0);

        a_scenario({8'd40, 8'd30, 8'd20, 8'd10}, 150);
        a_scenario({8'd40, 8'd30, 8'd20, 8'd0}, 12);
        for (int k = 0; k < 4; k++) begin
            s = $urandom;
            if ($urandom_range(0, 3) == 0)
                s[$urandom_range(0, 3)*8 +: 8] = 8'd0;
            a_scenario(s, int'($urandom_range(1, 200)));
        end

        // Abort on the third tick of the drop window.
        a_begin({8'd5, 8'd6, 8'd7, 8'd8});
        a_run_ticks(5);
        a_drop = 1'b1;
        step();
        a_drop = 1'b0;
        chk("ab_drop_en", a_drop_en, 1);
        a_tick = 1'b1;
        step();
        step();
        a_abort = 1'b1;
        step();
        a_abort = 1'b0;
        a_tick = 1'b0;
        chk("ab_drop_en0", a_drop_en, 0);
        chk("ab_busy", a_busy, 0);
        chk("ab_t_act", a_t_act, 0);
        chk("ab_done", a_done, 0);
        chk("ab_t_lim", a_t_lim, ref_lim(100, {8'd5, 8'd6, 8'd7, 8'd8}));
        step();
        chk("ab_done_later", a_done, 0);

        // Asynchronous reset in the middle of a run.
        a_begin({8'd1, 8'd2, 8'd3, 8'd4});
        a_run_ticks(37);
        chk("mid_t_act", a_t_act, 37);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_t_act", a_t_act, 0);
        chk("arst_t_lim", a_t_lim, 0);
        chk("arst_busy", a_busy, 0);
        chk("arst_drop_en", a_drop_en, 0);
        chk("arst_done", a_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("arst_idle", a_busy, 0);

        // Saturated limit, then timeout with no drop.
        b_sens  = 32'hFFFF_FFFF;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        step();
        chk("b_sat_t_lim", b_t_lim, 32'h0000_FFFF);
        b_tick = 1'b1;
        repeat (20) step();
        chk("b_to_t_act", b_t_act, 20);
        chk("b_to_drop_en", b_drop_en, 0);
        step();
        chk("b_to_done", b_done, 1);
        chk("b_to_t_act2", b_t_act, 20);
        chk("b_to_drop_en2", b_drop_en, 0);
        chk("b_to_busy", b_busy, 1);
        step();
        b_tick = 1'b0;
        chk("b_to_busy_fall", b_busy, 0);
        chk("b_to_done_fall", b_done, 0);

        // Zero hold behaves as one tick; faulty sensor gives zero limit.
        b_sens  = {8'd1, 8'd2, 8'd3, 8'd0};
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        step();
        chk("b_zero_t_lim", b_t_lim, 0);
        b_drop = 1'b1;
        step();
        b_drop = 1'b0;
        chk("b_h0_drop_en", b_drop_en, 1);
        step();
        chk("b_h0_hold", b_drop_en, 1);
        b_tick = 1'b1;
        step();
        b_tick = 1'b0;
        chk("b_h0_done", b_done, 1);
        chk("b_h0_drop_en0", b_drop_en, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
